// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared constants for the iterative multiplier sequencer.
//   - ALU operation select codes driven on alu_operation
//   - FSM state encoding
//   - CNT_W: iteration counter width (log2 of the 32-bit operand width)
package mult_seq_pkg;

  localparam int CNT_W = 5;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_seq.sv
// mult_seq: iterative 32x32 unsigned shift-and-add multiplier that borrows
// the EX-stage ALU through the alu_* ports (one ADD per CALC cycle).
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start captures
// a/b and moves to CALC. busy is high for the 32 CALC cycles, then done pulses
// for exactly one cycle. A start seen in the done cycle launches the next
// product with no idle gap. start during CALC is ignored.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, a, b           request pulse and operands
//   busy, done            CALC indicator, one-cycle completion pulse
//   hi, lo                product[63:32], product[31:0]
//   alu_in1, alu_in2,
//   alu_operation,
//   alu_cin, alu_binvert  drive to the shared external ALU
//   alu_result, alu_carry sum and carry-out returned by the ALU
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = mult_seq_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_operation,
  output logic             alu_cin,
  output logic             alu_binvert,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  import mult_seq_pkg::*;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [CNT_W-1:0]   cnt;

  logic accept;
  assign accept = start && (state == IDLE || state == DONE);

  // FSM, counter and partial-product shift register.
  // Each CALC step: {carry, sum} is the 33-bit partial sum; shifting it right
  // by one into p_hi and pushing sum[0] into the top of p_lo keeps the carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        CALC: begin
          p_hi <= {alu_carry, alu_result[WIDTH-1:1]};
          p_lo <= {alu_result[0], p_lo[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE: hold the product unless a new request arrives.
          if (accept) begin
            mcand <= a;
            p_hi  <= '0;
            p_lo  <= b;
            cnt   <= '0;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Status and product are decoded from registers only.
  assign busy = (state == CALC);
  assign done = (state == DONE);
  assign hi   = p_hi;
  assign lo   = p_lo;

  // ALU drive is forced to constant zeros outside CALC so the ALU stays quiet.
  assign alu_in1       = busy ? p_hi : '0;
  assign alu_in2       = (busy && p_lo[0]) ? mcand : '0;
  assign alu_operation = ALU_ADD;
  assign alu_cin       = 1'b0;
  assign alu_binvert   = 1'b0;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed bench for mult_seq with a behavioural 32-bit ALU
// wired to the alu_* ports.
module tb_mult_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [1:0]  alu_operation;
  logic        alu_cin;
  logic        alu_binvert;
  logic [31:0] alu_result;
  logic        alu_carry;

  int checks = 0;
  int errors = 0;

  mult_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_operation(alu_operation),
    .alu_cin(alu_cin), .alu_binvert(alu_binvert),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // Behavioural ALU: AND / OR / ADD with optional operand-2 invert.
  logic [31:0] alu_b;
  logic [32:0] alu_sum;
  assign alu_b   = alu_binvert ? ~alu_in2 : alu_in2;
  assign alu_sum = {1'b0, alu_in1} + {1'b0, alu_b} + {32'd0, alu_cin};
  always_comb begin
    alu_result = 32'd0;
    alu_carry  = 1'b0;
    case (alu_operation)
      2'b00: alu_result = alu_in1 & alu_b;
      2'b01: alu_result = alu_in1 | alu_b;
      2'b10: begin
        alu_result = alu_sum[31:0];
        alu_carry  = alu_sum[32];
      end
      default: alu_result = 32'd0;
    endcase
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one multiplication from IDLE and check timing and result.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name);
    int cyc;
    int busy_cnt;
    int done_cyc;
    int overlap;
    cyc = 0; busy_cnt = 0; done_cyc = -1; overlap = 0;
    @(negedge clk);
    start = 1'b1; a = op_a; b = op_b;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < 40 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (cyc == 1) check({name, "_alu_op"}, {62'd0, alu_operation}, 64'd2);
      if (done) done_cyc = cyc;
    end
    check({name, "_done_cycle"}, 64'(done_cyc), 64'd33);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({name, "_busy_done_overlap"}, 64'(overlap), 64'd0);
    check({name, "_product"}, {hi, lo}, {exp_hi, exp_lo});
    @(negedge clk);
    check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    check({name, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc;
    int done_cyc;
    int done_cnt;
    int first_done;
    int second_done;
    logic [31:0] first_lo;
    logic [31:0] second_lo;
    logic        busy_34;

    vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 32'd0,        32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 32'hFFFF_FFFF};
    vecs[5] = '{32'd1,        32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[7] = '{32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, 32'hEADB_EEF0};
    vecs[8] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_alu_in", {alu_in1, alu_in2}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_alu_ctl", {61'd0, alu_operation, alu_cin, alu_binvert}, 64'b1000);

    // Table-driven products
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, $sformatf("vec%0d", i));
    end
    check("idle_alu_in_after_run", {alu_in1, alu_in2}, 64'd0);

    // start during CALC is ignored
    cyc = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < 40 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      if (cyc == 11) start = 1'b0;
      if (done) done_cyc = cyc;
    end
    check("ignore_done_cycle", 64'(done_cyc), 64'd33);
    check("ignore_product", {hi, lo}, 64'd42);
    repeat (3) begin
      @(negedge clk);
      check("ignore_hold_idle", {hi, lo, 31'd0, busy | done}, {32'd0, 32'd42, 32'd0});
    end

    // Back-to-back with start held high
    cyc = 0; done_cnt = 0; first_done = -1; second_done = -1;
    first_lo = '0; second_lo = '0; busy_34 = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 32'd2; b = 32'd3;
    while (cyc < 80 && done_cnt < 2) begin
      @(negedge clk);
      cyc++;
      if (cyc == 34) begin busy_34 = busy; start = 1'b0; end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_done = cyc; first_lo = lo;
          a = 32'd4; b = 32'd5;
        end else begin
          second_done = cyc; second_lo = lo;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_done", 64'(first_done), 64'd33);
    check("b2b_first_lo", 64'(first_lo), 64'd6);
    check("b2b_no_idle_gap", {63'd0, busy_34}, 64'd1);
    check("b2b_second_done", 64'(second_done), 64'd66);
    check("b2b_second_lo", 64'(second_lo), 64'd20);
    @(negedge clk);

    // Reset in the middle of CALC
    cyc = 0;
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_status", {62'd0, busy, done}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_alu_in", {alu_in1, alu_in2}, 64'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("midreset_no_done", 64'(done_cnt), 64'd0);
    run_op(32'd3, 32'd5, 32'd0, 32'd15, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
